// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI path: D/C# encodings and transmitter states.
package oled_pkg;

  localparam logic OLED_CMD = 1'b0;
  localparam logic OLED_DAT = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_SHIFT,
    TX_HOLD,
    TX_GAP
  } oled_tx_state_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/oled_spi_tx.sv
// Byte-wide 4-wire SPI transmitter (mode 0, MSB first) with CS# setup/hold/gap timing
// and a one-shot arm flag so a held request is sent only once.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_en,
  input  logic       send_dc,
  input  logic [7:0] send_data,
  output logic       send_busy,
  output logic       oled_cs_n,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_dc
);

  localparam int unsigned MaxCnt = max4(SCLK_HALF, CS_SETUP, CS_HOLD, CS_GAP);
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] SetupEnd = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HalfEnd  = CntW'(SCLK_HALF - 1);
  localparam logic [CntW-1:0] HoldEnd  = CntW'(CS_HOLD - 1);
  localparam logic [CntW-1:0] GapEnd   = CntW'(CS_GAP - 1);

  if (SCLK_HALF < 1) begin : g_chk_half
    $error("SCLK_HALF must be >= 1");
  end
  if (CS_SETUP < 1) begin : g_chk_setup
    $error("CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_chk_hold
    $error("CS_HOLD must be >= 1");
  end
  if (CS_GAP < 1) begin : g_chk_gap
    $error("CS_GAP must be >= 1");
  end

  oled_tx_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            arm_q, arm_d;
  logic            busy_q, busy_d;
  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic            dc_q, dc_d;
  logic            accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    dc_d    = dc_q;

    accept = send_en & arm_q & (state_q == TX_IDLE);
    // Re-arm only once the request has been seen low.
    arm_d  = ~send_en | (arm_q & ~accept);

    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = TX_SETUP;
          shift_d = send_data;
          bit_d   = 3'd7;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          dc_d    = send_dc;
        end
      end
      TX_SETUP: begin
        if (cnt_q == SetupEnd) begin
          state_d = TX_SHIFT;
          cnt_d   = '0;
        end
      end
      TX_SHIFT: begin
        if (cnt_q == HalfEnd) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd0) begin
              state_d = TX_HOLD;
            end else begin
              bit_d   = bit_q - 3'd1;
              // MOSI is shift_q[7]; shifting presents the next bit at the start of a low half.
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
      end
      TX_HOLD: begin
        if (cnt_q == HoldEnd) begin
          state_d = TX_GAP;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          shift_d = '0;
        end
      end
      TX_GAP: begin
        if (cnt_q == GapEnd) begin
          state_d = TX_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      arm_q   <= 1'b1;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      arm_q   <= arm_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      dc_q    <= dc_d;
    end
  end

  assign send_busy = busy_q;
  assign oled_cs_n = cs_n_q;
  assign oled_sclk = sclk_q;
  assign oled_mosi = shift_q[7];
  assign oled_dc   = dc_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Bench for oled_spi_tx: default-timing and minimum-timing instances checked against
// transfer-level expectations (busy length, CS# window, SCLK rises, sampled byte).
module tb_oled_spi_tx;
  import oled_pkg::*;

  localparam int H0 = 2, S0 = 2, HO0 = 2, G0 = 2;
  localparam int H1 = 1, S1 = 1, HO1 = 1, G1 = 1;
  localparam int Busy0 = S0 + 16 * H0 + HO0 + G0;
  localparam int Busy1 = S1 + 16 * H1 + HO1 + G1;
  localparam int CsLow0 = Busy0 - G0;
  localparam int CsLow1 = Busy1 - G1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0, dc0 = 1'b0, en1 = 1'b0, dc1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic busy0, cs0, sck0, mosi0, odc0;
  logic busy1, cs1, sck1, mosi1, odc1;

  int total = 0;
  int bad = 0;
  int hi_run = 0;
  int last_gap = 0;

  always #5 clk = ~clk;

  oled_spi_tx #(.SCLK_HALF(H0), .CS_SETUP(S0), .CS_HOLD(HO0), .CS_GAP(G0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .send_en(en0), .send_dc(dc0), .send_data(data0),
    .send_busy(busy0), .oled_cs_n(cs0), .oled_sclk(sck0), .oled_mosi(mosi0), .oled_dc(odc0)
  );

  oled_spi_tx #(.SCLK_HALF(H1), .CS_SETUP(S1), .CS_HOLD(HO1), .CS_GAP(G1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .send_en(en1), .send_dc(dc1), .send_data(data1),
    .send_busy(busy1), .oled_cs_n(cs1), .oled_sclk(sck1), .oled_mosi(mosi1), .oled_dc(odc1)
  );

  // Length of the most recent CS# high run on instance 0, measured when CS# falls.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (cs0 === 1'b1) hi_run++;
      else begin
        if (hi_run > 0) last_gap = hi_run;
        hi_run = 0;
      end
    end
  end

  task automatic drive(input bit inst, input logic e, input logic d, input logic [7:0] x);
    if (inst) begin en1 = e; dc1 = d; data1 = x; end
    else begin en0 = e; dc0 = d; data0 = x; end
  endtask

  task automatic sample(input bit inst, output logic b, output logic cs, output logic sck,
                        output logic mo, output logic dv);
    if (inst) begin b = busy1; cs = cs1; sck = sck1; mo = mosi1; dv = odc1; end
    else begin b = busy0; cs = cs0; sck = sck0; mo = mosi0; dv = odc0; end
  endtask

  // Issue one request and observe the whole transfer, one sample per clock.
  task automatic run_xfer(input bit inst, input logic [7:0] data, input logic dc,
                          input bit drop_en, input bit mid_change,
                          output int lat, output int busy_cyc, output int cs_low,
                          output int rises, output logic [7:0] got, output bit dc_ok,
                          output int bad_sp);
    logic b, cs, sck, mo, dv, prev_sck;
    int last_rise, h;
    h = inst ? H1 : H0;
    lat = 0; busy_cyc = 0; cs_low = 0; rises = 0; got = '0; dc_ok = 1'b1; bad_sp = 0;
    prev_sck = 1'b0; last_rise = 0;
    drive(inst, 1'b1, dc, data);
    do begin
      @(posedge clk); #1;
      sample(inst, b, cs, sck, mo, dv);
      lat++;
    end while (!b && lat < 10);
    while (b && busy_cyc < 200) begin
      if (!cs) begin
        cs_low++;
        if (dv !== dc) dc_ok = 1'b0;
      end
      if (sck && !prev_sck) begin
        if (rises > 0 && busy_cyc - last_rise != 2 * h) bad_sp++;
        rises++;
        got = {got[6:0], mo};
        last_rise = busy_cyc;
      end
      prev_sck = sck;
      busy_cyc++;
      if (drop_en && busy_cyc == 1) drive(inst, 1'b0, dc, data);
      if (mid_change && busy_cyc == 10) drive(inst, 1'b1, ~dc, ~data);
      @(posedge clk); #1;
      sample(inst, b, cs, sck, mo, dv);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    total += 7;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy0); end
    if (cs0 !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs0); end
    if (sck0 !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sck0); end
    if (mosi0 !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi0); end
    if (odc0 !== 1'b0) begin bad++; $display("FAIL reset_dc got=%b want=0", odc0); end
    if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b want=0", busy1); end
    if (cs1 !== 1'b1) begin bad++; $display("FAIL reset_cs_n1 got=%b want=1", cs1); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cmd_byte;
    int lat, bc, cl, rs, sp; logic [7:0] got; bit dok;
    run_xfer(1'b0, 8'hAE, OLED_CMD, 1'b1, 1'b0, lat, bc, cl, rs, got, dok, sp);
    total += 7;
    if (lat !== 1) begin bad++; $display("FAIL cmd_latency got=%0d want=1", lat); end
    if (bc !== Busy0) begin bad++; $display("FAIL cmd_busy got=%0d want=%0d", bc, Busy0); end
    if (cl !== CsLow0) begin bad++; $display("FAIL cmd_cs_low got=%0d want=%0d", cl, CsLow0); end
    if (rs !== 8) begin bad++; $display("FAIL cmd_rises got=%0d want=8", rs); end
    if (got !== 8'hAE) begin bad++; $display("FAIL cmd_byte got=%h want=ae", got); end
    if (!dok) begin bad++; $display("FAIL cmd_dc got=changed want=0"); end
    if (sp !== 0) begin bad++; $display("FAIL cmd_sclk_period got=%0d_bad want=0", sp); end
  endtask

  task automatic test_handshake;
    int lat, bc, cl, rs, sp; logic [7:0] got; bit dok;
    run_xfer(1'b0, 8'hFF, OLED_DAT, 1'b1, 1'b0, lat, bc, cl, rs, got, dok, sp);
    total += 3;
    if (got !== 8'hFF) begin bad++; $display("FAIL hs_ff got=%h want=ff", got); end
    if (!dok) begin bad++; $display("FAIL hs_ff_dc got=changed want=1"); end
    if (bc !== Busy0) begin bad++; $display("FAIL hs_ff_busy got=%0d want=%0d", bc, Busy0); end
    run_xfer(1'b0, 8'h00, OLED_DAT, 1'b1, 1'b0, lat, bc, cl, rs, got, dok, sp);
    total += 4;
    if (got !== 8'h00 || rs !== 8) begin
      bad++; $display("FAIL hs_00 got=%h/%0d want=00/8", got, rs);
    end
    if (!dok) begin bad++; $display("FAIL hs_00_dc got=changed want=1"); end
    if (cl !== CsLow0) begin bad++; $display("FAIL hs_00_cs got=%0d want=%0d", cl, CsLow0); end
    if (last_gap !== G0 + 1) begin
      bad++; $display("FAIL hs_cs_gap got=%0d want=%0d", last_gap, G0 + 1);
    end
  endtask

  task automatic test_held_en;
    int lat, bc, cl, rs, sp, extra; logic [7:0] got; bit dok;
    run_xfer(1'b0, 8'h81, OLED_DAT, 1'b0, 1'b0, lat, bc, cl, rs, got, dok, sp);
    total += 2;
    if (got !== 8'h81) begin bad++; $display("FAIL held_byte got=%h want=81", got); end
    if (bc !== Busy0) begin bad++; $display("FAIL held_busy got=%0d want=%0d", bc, Busy0); end
    extra = 0;
    repeat (160) begin
      @(posedge clk); #1;
      if (busy0) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL held_retx got=%0d want=0", extra); end
    drive(1'b0, 1'b0, OLED_DAT, 8'h81);
    @(posedge clk); #1;
    run_xfer(1'b0, 8'h81, OLED_DAT, 1'b1, 1'b0, lat, bc, cl, rs, got, dok, sp);
    total++;
    if (got !== 8'h81 || lat !== 1) begin
      bad++; $display("FAIL held_rearm got=%h/%0d want=81/1", got, lat);
    end
  endtask

  task automatic test_mid_change;
    int lat, bc, cl, rs, sp; logic [7:0] got; bit dok;
    run_xfer(1'b0, 8'h3F, OLED_CMD, 1'b0, 1'b1, lat, bc, cl, rs, got, dok, sp);
    total += 3;
    if (got !== 8'h3F) begin bad++; $display("FAIL mid_byte got=%h want=3f", got); end
    if (!dok) begin bad++; $display("FAIL mid_dc_window got=changed want=0"); end
    if (odc0 !== 1'b0) begin bad++; $display("FAIL mid_dc_idle got=%b want=0", odc0); end
    drive(1'b0, 1'b0, OLED_CMD, 8'h00);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat, bc, cl, rs, sp, w; logic [7:0] got; bit dok;
    drive(1'b0, 1'b1, OLED_CMD, 8'h5A);
    w = 0;
    do begin @(posedge clk); #1; w++; end while (!busy0 && w < 10);
    drive(1'b0, 1'b0, OLED_CMD, 8'h5A);
    repeat (16) begin @(posedge clk); #1; end
    // Now in the high half of bit 4 (a 1 in 5A).
    total += 2;
    if (sck0 !== 1'b1) begin bad++; $display("FAIL rst_pre_sclk got=%b want=1", sck0); end
    if (mosi0 !== 1'b1) begin bad++; $display("FAIL rst_pre_mosi got=%b want=1", mosi0); end
    #2 rst_n = 1'b0;
    #1;
    total += 4;
    if (cs0 !== 1'b1) begin bad++; $display("FAIL rst_mid_cs_n got=%b want=1", cs0); end
    if (sck0 !== 1'b0) begin bad++; $display("FAIL rst_mid_sclk got=%b want=0", sck0); end
    if (mosi0 !== 1'b0) begin bad++; $display("FAIL rst_mid_mosi got=%b want=0", mosi0); end
    if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy0); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_xfer(1'b0, 8'hA5, OLED_DAT, 1'b1, 1'b0, lat, bc, cl, rs, got, dok, sp);
    total += 2;
    if (got !== 8'hA5) begin bad++; $display("FAIL rst_after_byte got=%h want=a5", got); end
    if (bc !== Busy0) begin bad++; $display("FAIL rst_after_busy got=%0d want=%0d", bc, Busy0); end
  endtask

  task automatic test_random;
    int lat, bc, cl, rs, sp; logic [7:0] got, x; bit dok; logic d;
    for (int i = 0; i < 6; i++) begin
      x = 8'($urandom_range(0, 255));
      d = 1'($urandom_range(0, 1));
      run_xfer(1'b0, x, d, 1'b1, 1'b0, lat, bc, cl, rs, got, dok, sp);
      total += 3;
      if (got !== x) begin bad++; $display("FAIL rand_byte[%0d] got=%h want=%h", i, got, x); end
      if (!dok) begin bad++; $display("FAIL rand_dc[%0d] got=changed want=%b", i, d); end
      if (bc !== Busy0 || rs !== 8) begin
        bad++; $display("FAIL rand_timing[%0d] got=%0d/%0d want=%0d/8", i, bc, rs, Busy0);
      end
    end
  endtask

  task automatic test_fast;
    int lat, bc, cl, rs, sp; logic [7:0] got; bit dok;
    run_xfer(1'b1, 8'h14, OLED_DAT, 1'b1, 1'b0, lat, bc, cl, rs, got, dok, sp);
    total += 5;
    if (bc !== Busy1) begin bad++; $display("FAIL fast_busy got=%0d want=%0d", bc, Busy1); end
    if (cl !== CsLow1) begin bad++; $display("FAIL fast_cs got=%0d want=%0d", cl, CsLow1); end
    if (got !== 8'h14) begin bad++; $display("FAIL fast_byte got=%h want=14", got); end
    if (rs !== 8) begin bad++; $display("FAIL fast_rises got=%0d want=8", rs); end
    if (sp !== 0) begin bad++; $display("FAIL fast_period got=%0d_bad want=0", sp); end
  endtask

  initial begin
    test_reset();
    test_cmd_byte();
    test_handshake();
    test_held_en();
    test_mid_change();
    test_reset_mid();
    test_random();
    test_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
